rsa_job_arbiter: RTL and testbench

- Shares a single modular-exponentiation engine (cipher = message^e mod n, 32-bit operands) between NUM_REQ independent requesters.
- Arbitration is round-robin. The block accepts one job at a time, sequences the engine with a start/done handshake and returns the tagged result to the requester.
- A watchdog bounds engine latency. Operands with an invalid modulus are rejected without issuing the job to the engine.
- Sits between the host-side job ports and the engine.

---
 rtl/rsa_job_arbiter_if.sv | 41 ++++
 rtl/rsa_job_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rsa_job_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_job_arbiter_if.sv
// Job-port, engine and response signals between the host requesters, the
// arbiter and the modular-exponentiation engine.
interface rsa_job_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_message;
    logic [NUM_REQ*32-1:0] req_e;
    logic [NUM_REQ*32-1:0] req_n;

    logic                  eng_start;
    logic                  eng_abort;
    logic [31:0]           eng_message;
    logic [31:0]           eng_e;
    logic [31:0]           eng_n;
    logic                  eng_done;
    logic [31:0]           eng_cipher;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_cipher;
    logic                  rsp_err;
    logic                  busy;

    // Host requesters and engine side.
    modport master (
        output req_valid, req_message, req_e, req_n, eng_done, eng_cipher, rsp_ready,
        input  req_ready, eng_start, eng_abort, eng_message, eng_e, eng_n,
               rsp_valid, rsp_id, rsp_cipher, rsp_err, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_message, req_e, req_n, eng_done, eng_cipher, rsp_ready,
        output req_ready, eng_start, eng_abort, eng_message, eng_e, eng_n,
               rsp_valid, rsp_id, rsp_cipher, rsp_err, busy
    );
endinterface

// File: rtl/rsa_job_arbiter.sv
// Round-robin arbiter sharing one modexp engine between NUM_REQ requesters,
// with modulus check and an engine-latency watchdog.
//
// state | meaning
// IDLE  | searching for a valid requester from rr_ptr, ready to accept
// ISSUE | operands latched; reject n<2 or start the engine
// WAIT  | engine running, watchdog counting
// RESP  | response held until rsp_ready
module rsa_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    rsa_job_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          r_state, w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [WD_W-1:0] r_wdog, w_wdog_nxt;
    logic            r_eng_start, w_eng_start_nxt;
    logic            r_eng_abort, w_eng_abort_nxt;
    logic [31:0]     r_message, w_message_nxt;
    logic [31:0]     r_e, w_e_nxt;
    logic [31:0]     r_n, w_n_nxt;
    logic [ID_W-1:0] r_rsp_id, w_rsp_id_nxt;
    logic [31:0]     r_rsp_cipher, w_rsp_cipher_nxt;
    logic            r_rsp_err, w_rsp_err_nxt;

    logic [ID_W-1:0]    w_grant;
    logic               w_any_valid;
    logic [NUM_REQ-1:0] w_ready;
    logic [31:0]        w_g_message, w_g_e, w_g_n;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int v_idx;
        w_grant     = r_rr_ptr;
        w_any_valid = 1'b0;
        v_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            if (!w_any_valid && bus.req_valid[v_idx]) begin
                w_grant     = ID_W'(v_idx);
                w_any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_g_message = '0;
        w_g_e       = '0;
        w_g_n       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_g_message = bus.req_message[32*i +: 32];
                w_g_e       = bus.req_e[32*i +: 32];
                w_g_n       = bus.req_n[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (reset_n && r_state == IDLE && w_any_valid) w_ready[w_grant] = 1'b1;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_wdog_nxt       = r_wdog;
        w_eng_start_nxt  = 1'b0;
        w_eng_abort_nxt  = 1'b0;
        w_message_nxt    = r_message;
        w_e_nxt          = r_e;
        w_n_nxt          = r_n;
        w_rsp_id_nxt     = r_rsp_id;
        w_rsp_cipher_nxt = r_rsp_cipher;
        w_rsp_err_nxt    = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_message_nxt   = w_g_message;
                    w_e_nxt         = w_g_e;
                    w_n_nxt         = w_g_n;
                    w_rsp_id_nxt    = w_grant;
                    // Start is registered here so it is high during the ISSUE cycle.
                    w_eng_start_nxt = (w_g_n >= 32'd2);
                    w_state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (r_n < 32'd2) begin
                    w_rsp_cipher_nxt = '0;
                    w_rsp_err_nxt    = 1'b1;
                    w_state_nxt      = RESP;
                end else begin
                    w_wdog_nxt  = '0;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_wdog_nxt = r_wdog + 1'b1;
                if (bus.eng_done) begin
                    w_rsp_cipher_nxt = bus.eng_cipher;
                    w_rsp_err_nxt    = 1'b0;
                    w_state_nxt      = RESP;
                end else if (r_wdog == WD_LAST) begin
                    w_eng_abort_nxt  = 1'b1;
                    w_rsp_cipher_nxt = '0;
                    w_rsp_err_nxt    = 1'b1;
                    w_state_nxt      = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rr_ptr_nxt = (r_rsp_id == ID_LAST) ? '0 : r_rsp_id + 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_wdog       <= '0;
            r_eng_start  <= 1'b0;
            r_eng_abort  <= 1'b0;
            r_message    <= '0;
            r_e          <= '0;
            r_n          <= '0;
            r_rsp_id     <= '0;
            r_rsp_cipher <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_wdog       <= w_wdog_nxt;
            r_eng_start  <= w_eng_start_nxt;
            r_eng_abort  <= w_eng_abort_nxt;
            r_message    <= w_message_nxt;
            r_e          <= w_e_nxt;
            r_n          <= w_n_nxt;
            r_rsp_id     <= w_rsp_id_nxt;
            r_rsp_cipher <= w_rsp_cipher_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.eng_start   = r_eng_start;
    assign bus.eng_abort   = r_eng_abort;
    assign bus.eng_message = r_message;
    assign bus.eng_e       = r_e;
    assign bus.eng_n       = r_n;
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_cipher  = r_rsp_cipher;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Randomized bench for rsa_job_arbiter: an event-timeline model of each job is
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_rsa_job_arbiter;
    localparam int NR = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    rsa_job_arbiter_if #(.NUM_REQ(NR)) bus ();

    rsa_job_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] m, input logic [31:0] e,
                                           input logic [31:0] n);
        logic [63:0] r, b, nn;
        nn = {32'd0, n};
        r  = 64'd1 % nn;
        b  = {32'd0, m} % nn;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[31:0];
    endfunction

    // ---------------- engine model ----------------
    int          eng_mode = 0;   // 0 fixed latency, 1 silent, 2 random
    int          eng_lat = 3;
    bit          pend = 0;
    int          done_at = 0;
    logic [31:0] pend_val = '0;
    int          stray_at = -1;
    int          last_done = -1;

    always begin
        @(posedge clk); #1;
        bus.eng_done   = 1'b0;
        bus.eng_cipher = $urandom;
        if (pend && cyc == done_at) begin
            bus.eng_done   = 1'b1;
            bus.eng_cipher = pend_val;
            pend           = 0;
            last_done      = cyc;
        end
        if (cyc == stray_at) begin
            bus.eng_done   = 1'b1;
            bus.eng_cipher = 32'hdead_beef;
        end
        if (bus.eng_start) begin
            int lat;
            bit silent;
            lat    = eng_lat;
            silent = (eng_mode == 1);
            if (eng_mode == 2) begin
                silent = ($urandom_range(0, 7) == 0);
                lat    = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(1, 66);
            end
            if (!silent) begin
                pend     = 1;
                done_at  = cyc + lat;
                pend_val = modexp(bus.eng_message, bus.eng_e, bus.eng_n);
            end
        end
    end

    // ---------------- requester agent ----------------
    logic [NR-1:0] acc_mask = '0;
    logic [NR-1:0] auto_req = '0;

    function automatic logic [31:0] gen_n(input bit allow_bad);
        logic [31:0] v;
        if (allow_bad && $urandom_range(0, 9) == 0) return 32'($urandom_range(0, 1));
        v = $urandom;
        if ($urandom_range(0, 1) == 0) v = 32'($urandom_range(2, 1000));
        if (v < 2) v = 2;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [31:0] m, input logic [31:0] e,
                           input logic [31:0] n);
        bus.req_message[32*i +: 32] = m;
        bus.req_e[32*i +: 32]       = e;
        bus.req_n[32*i +: 32]       = n;
        bus.req_valid[i]            = 1'b1;
    endtask

    task automatic rand_req(input int i, input bit allow_bad);
        set_req(i, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, gen_n(allow_bad));
    endtask

    always begin
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_mask[i]) begin
                if (auto_req[i]) rand_req(i, 0);
                else bus.req_valid[i] = 1'b0;
            end
        end
    end

    // ---------------- timeline model and per-cycle compare ----------------
    bit          m_active = 0;
    int          m_tacc = 0;
    int          m_owner = 0;
    int          m_rr = 0;
    logic [31:0] m_msg = '0, m_e = '0, m_n = '0;
    bit          m_known = 0;
    int          m_tresp = 0;
    logic [31:0] m_cipher = '0;
    bit          m_err = 0;
    bit          m_abort = 0;
    bit          prev_rspv = 0;

    int acc_cyc[$], acc_id[$], start_cyc[$], abort_cyc[$], rspv_cyc[$], hs_cyc[$];
    int rsp_id_l[$];
    logic [31:0] rsp_cip_l[$];
    bit rsp_err_l[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_start", bus.eng_start, 0);
            chk("rst_abort", bus.eng_abort, 0);
            chk("rst_rspv", bus.rsp_valid, 0);
            chk("rst_rsp", {bus.rsp_id, bus.rsp_err, bus.rsp_cipher}, 0);
            chk("rst_ops", {bus.eng_message, bus.eng_e} | bus.eng_n, 0);
            m_active = 0; m_rr = 0; m_msg = '0; m_e = '0; m_n = '0; m_known = 0;
            prev_rspv = 0; acc_mask = '0;
        end else begin
            logic [NR-1:0] exp_ready;
            bit exp_rspv;
            int g;
            exp_ready = '0;
            g = -1;
            if (!m_active) begin
                for (int k = 0; k < NR; k++) begin
                    int j;
                    j = (m_rr + k) % NR;
                    if (g < 0 && bus.req_valid[j]) g = j;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            exp_rspv = m_active && m_known && cyc >= m_tresp;
            chk("ready", bus.req_ready, exp_ready);
            chk("busy", bus.busy, m_active);
            chk("eng_start", bus.eng_start, m_active && cyc == m_tacc + 1 && m_n >= 2);
            chk("eng_abort", bus.eng_abort, m_active && m_known && m_abort && cyc == m_tresp);
            chk("rsp_valid", bus.rsp_valid, exp_rspv);
            chk("eng_ops", {bus.eng_message, bus.eng_e}, {m_msg, m_e});
            chk("eng_n", bus.eng_n, m_n);
            if (exp_rspv) begin
                chk("rsp_id", bus.rsp_id, m_owner);
                chk("rsp_cipher", bus.rsp_cipher, m_cipher);
                chk("rsp_err", bus.rsp_err, m_err);
            end
            // Observation logs for the directed scenarios.
            acc_mask = bus.req_valid & bus.req_ready;
            for (int i = 0; i < NR; i++)
                if (acc_mask[i]) begin acc_cyc.push_back(cyc); acc_id.push_back(i); end
            if (bus.eng_start) start_cyc.push_back(cyc);
            if (bus.eng_abort) abort_cyc.push_back(cyc);
            if (bus.rsp_valid && !prev_rspv) begin
                rspv_cyc.push_back(cyc);
                rsp_id_l.push_back(int'(bus.rsp_id));
                rsp_cip_l.push_back(bus.rsp_cipher);
                rsp_err_l.push_back(bus.rsp_err);
            end
            if (bus.rsp_valid && bus.rsp_ready) hs_cyc.push_back(cyc);
            prev_rspv = bus.rsp_valid && !bus.rsp_ready;
            // Advance the model to the next cycle.
            if (!m_active) begin
                if (g >= 0) begin
                    m_active = 1; m_tacc = cyc; m_owner = g; m_abort = 0;
                    m_msg = bus.req_message[32*g +: 32];
                    m_e   = bus.req_e[32*g +: 32];
                    m_n   = bus.req_n[32*g +: 32];
                    if (m_n < 2) begin
                        m_known = 1; m_tresp = cyc + 2; m_cipher = '0; m_err = 1;
                    end else m_known = 0;
                end
            end else if (!m_known) begin
                if (cyc >= m_tacc + 2 && bus.eng_done) begin
                    m_known = 1; m_tresp = cyc + 1; m_cipher = bus.eng_cipher; m_err = 0;
                end else if (cyc == m_tacc + 1 + TO) begin
                    m_known = 1; m_tresp = cyc + 1; m_cipher = '0; m_err = 1; m_abort = 1;
                end
            end else if (cyc >= m_tresp && bus.rsp_ready) begin
                m_active = 0;
                m_rr = (m_owner + 1) % NR;
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_acc(input int target, input int budget, input string nm);
        int k = 0;
        while (acc_cyc.size() < target && k < budget) begin tick(); k++; end
        chk(nm, acc_cyc.size(), target);
    endtask

    task automatic wait_rspv(input int target, input int budget, input string nm);
        int k = 0;
        while (rspv_cyc.size() < target && k < budget) begin tick(); k++; end
        chk(nm, rspv_cyc.size(), target);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        tick();
        while (bus.busy && k < budget) begin tick(); k++; end
        chk(nm, bus.busy, 0);
    endtask

    initial begin
        int c0, nr, ns, nh;
        bus.req_valid = '0; bus.req_message = '0; bus.req_e = '0; bus.req_n = '0;
        bus.rsp_ready = 1'b0; bus.eng_done = 1'b0; bus.eng_cipher = '0;
        repeat (3) tick();
        chk("rst_idle_busy", bus.busy, 0);
        reset_n = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();

        // Single job on requester 2: 5^3 mod 33 = 26, engine latency 40.
        eng_mode = 0; eng_lat = 40;
        nr = rspv_cyc.size();
        c0 = cyc;
        set_req(2, 32'd5, 32'd3, 32'd33);
        wait_rspv(nr + 1, 200, "t1_wait");
        chk("t1_acc_cyc", acc_cyc[$], c0);
        chk("t1_start_cyc", start_cyc[$], c0 + 1);
        chk("t1_rspv_cyc", rspv_cyc[$], c0 + 42);
        chk("t1_rspv_after_done", rspv_cyc[$], last_done + 1);
        chk("t1_id", rsp_id_l[$], 2);
        chk("t1_cipher", rsp_cip_l[$], 32'd26);
        chk("t1_err", rsp_err_l[$], 0);
        wait_idle(20, "t1_idle");

        // Fairness from reset with all requesters continuously valid.
        reset_n = 1'b0;
        tick();
        eng_lat = 3;
        auto_req = '1;
        for (int i = 0; i < NR; i++) rand_req(i, 0);
        nr = acc_cyc.size();
        reset_n = 1'b1;
        wait_acc(nr + 5, 200, "t2_wait5");
        for (int k = 0; k < 5; k++) chk("t2_order", acc_id[nr + k], k % NR);
        bus.req_valid[1] = 1'b0;
        auto_req = '0;
        wait_acc(nr + 6, 100, "t2_wait6");
        chk("t2_skip1", acc_id[nr + 5], 2);
        bus.req_valid = '0;
        wait_idle(50, "t2_idle");

        // Invalid modulus on requester 0.
        ns = start_cyc.size(); nr = rspv_cyc.size();
        c0 = cyc;
        set_req(0, 32'd7, 32'd5, 32'd1);
        wait_rspv(nr + 1, 20, "t3_wait");
        chk("t3_acc_cyc", acc_cyc[$], c0);
        chk("t3_rspv_cyc", rspv_cyc[$], c0 + 2);
        chk("t3_err", rsp_err_l[$], 1);
        chk("t3_cipher", rsp_cip_l[$], 0);
        wait_idle(20, "t3_idle");
        chk("t3_no_start", start_cyc.size(), ns);

        // Watchdog: silent engine, then a stray done.
        eng_mode = 1;
        nr = rspv_cyc.size();
        c0 = cyc;
        set_req(1, 32'd9, 32'd17, 32'd97);
        wait_rspv(nr + 1, 200, "t4_wait");
        chk("t4_abort_cyc", abort_cyc[$], c0 + 66);
        chk("t4_rspv_cyc", rspv_cyc[$], c0 + 66);
        chk("t4_err", rsp_err_l[$], 1);
        chk("t4_cipher", rsp_cip_l[$], 0);
        wait_idle(20, "t4_idle");
        nh = hs_cyc.size(); nr = rspv_cyc.size();
        stray_at = cyc + 3;
        repeat (8) tick();
        chk("t4_stray_rspv", rspv_cyc.size(), nr);
        chk("t4_stray_hs", hs_cyc.size(), nh);

        // Back-pressure on the response while requester 3 waits.
        eng_mode = 0; eng_lat = 5;
        bus.rsp_ready = 1'b0;
        nr = rspv_cyc.size();
        set_req(0, 32'd11, 32'd7, 32'd143);
        wait_rspv(nr + 1, 50, "t5_wait");
        set_req(3, 32'd2, 32'd10, 32'd1000);
        nr = acc_cyc.size();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_hold_ready", bus.req_ready, 0);
            chk("t5_hold_rsp", {bus.rsp_valid, bus.rsp_id}, {1'b1, 2'd0});
            chk("t5_hold_cipher", bus.rsp_cipher, modexp(32'd11, 32'd7, 32'd143));
        end
        bus.rsp_ready = 1'b1;
        wait_acc(nr + 1, 10, "t5_wait_acc");
        chk("t5_acc_id", acc_id[$], 3);
        chk("t5_acc_after_hs", acc_cyc[$], hs_cyc[$] + 1);
        wait_idle(30, "t5_idle");
        chk("t5_cipher", rsp_cip_l[$], 32'd24);

        // Reset in the middle of WAIT with rr_ptr advanced to 2 beforehand.
        eng_lat = 2;
        set_req(1, 32'd3, 32'd3, 32'd5);
        wait_idle(30, "t6_pre_idle");
        eng_lat = 30;
        set_req(2, 32'd4, 32'd5, 32'd77);
        repeat (10) tick();
        chk("t6_in_wait", bus.busy, 1);
        nr = rspv_cyc.size(); nh = hs_cyc.size();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_ops", bus.eng_message | bus.eng_n, 0);
        tick();
        reset_n = 1'b1;
        repeat (40) tick();
        chk("t6_no_rspv", rspv_cyc.size(), nr);
        chk("t6_no_hs", hs_cyc.size(), nh);
        eng_lat = 3;
        nr = acc_cyc.size();
        set_req(2, 32'd6, 32'd3, 32'd55);
        set_req(0, 32'd8, 32'd3, 32'd55);
        wait_acc(nr + 1, 10, "t6_wait_acc");
        chk("t6_first_after_rst", acc_id[$], 0);
        wait_acc(nr + 2, 40, "t6_wait_acc2");
        wait_idle(30, "t6_idle");

        // Randomized traffic.
        eng_mode = 2;
        for (int t = 0; t < 3000; t++) begin
            tick();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 7) == 0) rand_req(i, 1);
                end else if ($urandom_range(0, 63) == 0) bus.req_valid[i] = 1'b0;
            end
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle(300, "drain_idle");
        chk("random_jobs_seen", rspv_cyc.size() > 30, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
